// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI command decoder: FSM state encoding, command
// byte layout, frame length and the default idle byte driven on MISO.
// -----------------------------------------------------------------------------
package spi_pkg;

  // Frame sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for slave select to fall
    ST_CMD  = 2'd1,  // waiting for the command byte
    ST_DATA = 2'd2,  // collecting / presenting the four data bytes
    ST_DONE = 2'd3   // frame complete, waiting for slave select to rise
  } state_e;

  // Command byte: bit 7 selects write (1) or read (0); low bits are the address.
  localparam int unsigned OPCODE_BIT = 7;

  // One command byte followed by a 32-bit payload, MSB first.
  localparam int unsigned FRAME_BYTES = 5;
  localparam int unsigned DATA_BYTES  = FRAME_BYTES - 1;

  // Byte shifted out whenever no read data is pending.
  localparam logic [7:0] IDLE_TX_DEFAULT = 8'h5A;

  function automatic logic is_write(input logic [7:0] cmd);
    return cmd[OPCODE_BIT];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous level signal.
//
// Ports
//   clk_i  destination clock
//   rst_i  synchronous active-high reset; both flops load RST_VAL
//   d_i    asynchronous input
//   q_o    synchronised output (two clk_i cycles of latency)
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state is only ever assigned with <=, so every flop
  // samples the pre-edge value of the others and the chain shifts by one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_cmd_decoder.sv
// -----------------------------------------------------------------------------
// spi_cmd_decoder
// Decodes 5-byte SPI frames (command + 32-bit payload, MSB first) into
// single-cycle register write / read transactions. Read data is returned on
// the MISO byte path during the same frame.
//
// Ports
//   sysClk    system clock, single clock domain
//   usrReset  synchronous active-high reset
//   SS        raw active-low slave select (asynchronous, synchronised here)
//   rxValid   one-cycle strobe: rx holds a received byte
//   rx        received byte
//   tx        next byte to shift out on MISO
//   wrStrobe  one-cycle register write pulse, with wrAddr / wrData
//   rdReq     one-cycle register read request, with rdAddr
//   rdData    read data, sampled in the cycle that rdReq is high
//   frameErr  one-cycle pulse when a frame is aborted by SS rising early
//   frameCnt  number of completed frames (wraps)
//
// ADDR_W must not exceed 7: bit 7 of the command byte is the opcode.
// FRAME_CNT_RST is the value frameCnt takes in reset (normally zero).
// -----------------------------------------------------------------------------
module spi_cmd_decoder
  import spi_pkg::*;
#(
  parameter int unsigned ADDR_W        = 7,
  parameter logic [7:0]  IDLE_TX       = IDLE_TX_DEFAULT,
  parameter logic [15:0] FRAME_CNT_RST = 16'h0000
) (
  input  logic              sysClk,
  input  logic              usrReset,
  input  logic              SS,
  input  logic              rxValid,
  input  logic [7:0]        rx,
  output logic [7:0]        tx,
  output logic              wrStrobe,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [31:0]       wrData,
  output logic              rdReq,
  output logic [ADDR_W-1:0] rdAddr,
  input  logic [31:0]       rdData,
  output logic              frameErr,
  output logic [15:0]       frameCnt
);

  localparam logic [1:0] LAST_DATA_IDX = 2'(DATA_BYTES - 1);

  // ---------------------------------------------------------------------------
  // Slave select synchronisation and edge detection
  // ---------------------------------------------------------------------------
  logic ss_sync;
  logic ss_prev_q;
  logic ss_active;
  logic ss_fall;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_ss_sync (
    .clk_i (sysClk),
    .rst_i (usrReset),
    .d_i   (SS),
    .q_o   (ss_sync)
  );

  assign ss_active = ~ss_sync;
  assign ss_fall   = ss_prev_q & ~ss_sync;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e              state_q,     state_d;
  logic                is_wr_q,     is_wr_d;
  logic [1:0]          byte_cnt_q,  byte_cnt_d;
  logic                wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]   wr_addr_q,   wr_addr_d;
  logic [31:0]         wr_data_q,   wr_data_d;
  logic                rd_req_q,    rd_req_d;
  logic [ADDR_W-1:0]   rd_addr_q,   rd_addr_d;
  logic [31:0]         tx_sr_q,     tx_sr_d;
  logic                tx_valid_q,  tx_valid_d;
  logic                frame_err_q, frame_err_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets its hold (or idle) value before the case, so
  // no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    is_wr_d     = is_wr_q;
    byte_cnt_d  = byte_cnt_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_req_d    = 1'b0;
    rd_addr_d   = rd_addr_q;
    tx_sr_d     = tx_sr_q;
    tx_valid_d  = tx_valid_q;
    frame_err_d = 1'b0;
    frame_cnt_d = frame_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        // Bytes arriving before the frame starts are not ours.
        tx_valid_d = 1'b0;
        if (ss_fall) begin
          state_d = ST_CMD;
        end
      end

      ST_CMD: begin
        // SS rising is checked first: a byte coincident with it is dropped.
        if (!ss_active) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (rxValid) begin
          is_wr_d    = is_write(rx);
          byte_cnt_d = 2'd0;
          state_d    = ST_DATA;
          if (is_write(rx)) begin
            wr_addr_d = rx[ADDR_W-1:0];
          end else begin
            rd_addr_d = rx[ADDR_W-1:0];
            rd_req_d  = 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (!ss_active) begin
          frame_err_d = 1'b1;
          tx_valid_d  = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          // Read data returns the cycle after the request.
          if (rd_req_q) begin
            tx_sr_d    = rdData;
            tx_valid_d = 1'b1;
          end
          if (rxValid) begin
            wr_data_d  = {wr_data_q[23:0], rx};
            byte_cnt_d = byte_cnt_q + 2'd1;
            // A byte clocked out moves MISO on to the next lower byte; this
            // also covers a byte landing in the same cycle as the load.
            if (!is_wr_q) begin
              tx_sr_d = {tx_sr_d[23:0], 8'h00};
            end
            if (byte_cnt_q == LAST_DATA_IDX) begin
              state_d     = ST_DONE;
              tx_valid_d  = 1'b0;
              frame_cnt_d = frame_cnt_q + 16'd1;
              wr_strobe_d = is_wr_q;
            end
          end
        end
      end

      ST_DONE: begin
        // Overrun bytes are ignored until SS rises.
        if (!ss_active) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sysClk) begin
    if (usrReset) begin
      state_q     <= ST_IDLE;
      ss_prev_q   <= 1'b1;
      is_wr_q     <= 1'b0;
      byte_cnt_q  <= 2'd0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      tx_sr_q     <= '0;
      tx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= FRAME_CNT_RST;
    end else begin
      state_q     <= state_d;
      ss_prev_q   <= ss_sync;
      is_wr_q     <= is_wr_d;
      byte_cnt_q  <= byte_cnt_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_req_q    <= rd_req_d;
      rd_addr_q   <= rd_addr_d;
      tx_sr_q     <= tx_sr_d;
      tx_valid_q  <= tx_valid_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign tx       = tx_valid_q ? tx_sr_q[31:24] : IDLE_TX;
  assign wrStrobe = wr_strobe_q;
  assign wrAddr   = wr_addr_q;
  assign wrData   = wr_data_q;
  assign rdReq    = rd_req_q;
  assign rdAddr   = rd_addr_q;
  assign frameErr = frame_err_q;
  assign frameCnt = frame_cnt_q;

endmodule

// File: doc/spi_cmd_decoder.md
SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, register address width taken from the command byte.
REQ-002 SHALL have parameter IDLE_TX, default 8'h5A, byte presented on tx when no read data is pending.
REQ-003 SHALL have port sysClk  input  1  system clock (100 MHz); all logic in this single clock domain.
REQ-004 SHALL have port usrReset  input  1  reset, synchronous to sysClk, active-high.
REQ-005 SHALL have port SS  input  1  raw SPI slave select from pin, active-low, asynchronous to sysClk.
REQ-006 SHALL have port rxValid  input  1  single-cycle strobe: rx holds a complete received byte.
REQ-007 SHALL have port rx  input  8  received byte from the SPI byte interface.
REQ-008 SHALL have port tx  output  8  next byte to shift out on MISO.
REQ-009 SHALL have port wrStrobe  output  1  single-cycle register write pulse.
REQ-010 SHALL have port wrAddr  output  ADDR_W  write address, valid with wrStrobe.
REQ-011 SHALL have port wrData  output  32  write data, valid with wrStrobe.
REQ-012 SHALL have port rdReq  output  1  single-cycle register read request.
REQ-013 SHALL have port rdAddr  output  ADDR_W  read address, valid with rdReq.
REQ-014 SHALL have port rdData  input  32  read data, sampled exactly 1 cycle after rdReq.
REQ-015 SHALL have port frameErr  output  1  single-cycle pulse on aborted frame.
REQ-016 SHALL have port frameCnt  output  16  count of completed frames.

Function
REQ-017 SHALL synchronise SS through a 2-flop synchroniser (reset value 1); "active" means synchronised SS = 0.
REQ-018 SHALL define a frame as 5 bytes while SS active: command byte, then 4 data bytes MSB first.
REQ-019 SHALL decode command byte: bit7 = 1 write, 0 read; bits[ADDR_W-1:0] = address; unused bits ignored.
REQ-020 SHALL implement FSM states IDLE, CMD, DATA, DONE.
REQ-021 SHALL move IDLE->CMD when synchronised SS falls; rxValid in IDLE ignored.
REQ-022 SHALL, in CMD on rxValid, latch opcode/address, clear byte counter, go to DATA; for read, assert rdReq that same next cycle.
REQ-023 SHALL, 1 cycle after rdReq, load rdData into a 32-bit tx shift register and drive tx = rdData[31:24].
REQ-024 SHALL, in DATA on each rxValid, shift rx into 32-bit wrData accumulator MSB first and increment 2-bit byte counter; on read frames advance tx to the next lower byte.
REQ-025 SHALL, on the 4th data rxValid (counter wraps 3->0), go to DONE; for write frames pulse wrStrobe with wrAddr/wrData next cycle.
REQ-026 SHALL, in DONE, increment frameCnt once (wraps 16'hFFFF->0), drive tx = IDLE_TX, ignore further rxValid, return to IDLE when SS deasserts.
REQ-027 SHALL, when SS deasserts in CMD or DATA, pulse frameErr once, emit no wrStrobe, return to IDLE, tx = IDLE_TX.
REQ-028 SHALL treat rxValid coincident with SS deassert as not received (abort wins).
REQ-029 SHALL drive tx = IDLE_TX in IDLE, CMD, and write frames.
REQ-030 SHALL treat SS deassert in CMD with zero bytes as abort (frameErr pulses).

Reset
REQ-031 SHALL, while usrReset high at a sysClk edge, set: state IDLE, SS sync flops 1, tx = IDLE_TX, wrStrobe/rdReq/frameErr 0, wrAddr/rdAddr 0, wrData 0, frameCnt 0.
REQ-032 SHALL, on reset mid-frame, discard the frame silently (no frameErr, no wrStrobe) and require a fresh SS falling edge.

Structure
REQ-033 SHALL place FSM state encoding, opcode bit position, frame byte count (5) and IDLE_TX default in shared package spi_pkg.
REQ-034 SHALL be a single module with the SS synchroniser as sub-module sync_2ff.

Verification
REQ-035 SHALL test write: SS low, bytes 85,DE,AD,BE,EF, SS high -> one wrStrobe, wrAddr=05, wrData=DEADBEEF, frameCnt=1.
REQ-036 SHALL test read: bytes 03,00,00,00,00 with rdData=12345678 -> rdReq with rdAddr=03; tx sequence 12,34,56,78 then 5A.
REQ-037 SHALL test abort: SS high after 85,11,22 -> frameErr 1 cycle, no wrStrobe, frameCnt unchanged.
REQ-038 SHALL test overrun: 7 bytes 81,01,02,03,04,FF,FF -> single wrStrobe wrData=01020304, extra bytes ignored.
REQ-039 SHALL test reset mid-write after 3 bytes -> all outputs at reset values, next full frame 82,AA,BB,CC,DD writes AABBCCDD to 02.
REQ-040 SHALL test frameCnt wrap: preload by 65536 frames -> frameCnt returns to 0.
